pwm_color_decoder: RTL and testbench
====================================

Name: pwm_color_decoder

Overview:
- Receive-side counterpart of color_mixer: recovers a 24-bit RGB colour from the 3-bit PWM stream and its period strobe.
- Counts high cycles per channel over one PWM period.
- Used as a scoreboard in mixer loopback benches and as a feedback monitor on hardware.
- Same clock domain as the mixer; no synchronisers.

Parameters:
- CW, 8, channel width in bits; PWM period is 2**CW cycles; colour width is 3*CW.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- rgb_pwm_i  input  3  PWM lines: [2]=R, [1]=G, [0]=B.
- frame_i  input  1  one-cycle strobe in the last cycle of each PWM period (mixer timeout_o).
- color_o  output  3*CW  last good colour: [23:16]=R, [15:8]=G, [7:0]=B at CW=8.
- valid_o  output  1  one-cycle pulse when color_o updates.
- error_o  output  1  one-cycle pulse on a malformed period.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, all counters 0, color_o=0, valid_o=0, error_o=0. Deassertion takes effect at the next clk_i edge.
- Reset mid-window: partial counts are discarded and color_o is cleared.
- States: IDLE, MEASURE.
- IDLE:
  - rgb_pwm_i is ignored.
  - frame_i=1 -> MEASURE, with len_cnt=0 and hi_cnt[R,G,B]=0.
- MEASURE, every cycle:
  - len_cnt += 1 (width CW+1).
  - hi_cnt[c] += rgb_pwm_i[c] (width CW+1).
  - A window is the cycles after the opening strobe up to and including the closing strobe cycle. The closing cycle's samples count.
- MEASURE with frame_i=1 (closing cycle): compute final length L = len_cnt+1, including the current cycle.
  - If L == 2**CW: at the next edge color_o[c] = min(hi_cnt[c] incl. current sample, 2**CW-1) and valid_o=1 for one cycle.
  - Otherwise: error_o=1 for one cycle and color_o holds.
  - Either way, counters restart at 0 and the state stays MEASURE. The closing strobe opens the next window, so back-to-back periods lose no cycles.
- Saturation: a channel held high for the full period (2**CW highs) reports 2**CW-1.
- Overrun: in MEASURE, if len_cnt reaches 2**CW without frame_i, then error_o=1 for one cycle, state -> IDLE, counters cleared, color_o holds.
- Latency: valid_o and the new color_o appear one cycle after the closing frame_i cycle.
- valid_o and error_o are never both 1 in the same cycle.
- The first frame_i after reset only opens a window, so the first valid_o comes one full period later.

Decomposition:
- Shared package/header holds:
  - channel bit positions: R_IDX=2, G_IDX=1, B_IDX=0;
  - state encodings: ST_IDLE=0, ST_MEASURE=1;
  - CW default.
- One sub-module, pwm_duty_counter, instantiated 3 times:
  - inputs: clr, en, pwm bit;
  - output: saturated CW-bit duty count.
- The top level keeps the FSM, the length counter, and the color_o/valid_o/error_o registers.

Test Plan:
- Loopback with color_mixer, color_i=24'h7f1fff, rst_i high 10 ns → color_o=24'h7f1fff with valid_o pulsing once per 256-cycle period; error_o never asserts.
- Direct drive of full-period highs: R high 256/256, G 0/256, B 128/256 → color_o=24'hff0080; saturation path exercised.
- frame_i strobes 200 cycles apart → error_o pulses once and color_o keeps its previous value. Next correct 256-cycle period → valid_o.
- frame_i withheld after the opening strobe → error_o at the 256th window cycle, then IDLE. The next frame_i reopens a window, and valid_o follows 256 cycles later.
- rst_i asserted mid-window (cycle 100) → outputs clear asynchronously, no valid_o. After release, the first frame_i only opens a window.
- Colour changed at a period boundary (24'h000000 → 24'h010203 via the mixer) → successive valid_o pulses report 24'h000000, then 24'h010203, with no mixed intermediate value.

Source files
------------

// File: rtl/pwm_color_decoder_pkg.sv
// Shared definitions for the PWM colour decoder: channel positions,
// FSM encoding and default channel width.
package pwm_color_decoder_pkg;

  // Default channel width; the PWM period is 2**CW cycles.
  localparam int CW_DEFAULT = 8;

  // Bit positions of each colour channel on the PWM bus. The same index
  // selects the channel's CW-bit slice inside the packed colour word.
  localparam int R_IDX  = 2;
  localparam int G_IDX  = 1;
  localparam int B_IDX  = 0;
  localparam int NUM_CH = 3;

  // Decoder FSM: waiting for an opening strobe, or measuring a window.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_duty_counter.sv
// Per-channel high-cycle counter. The duty output already includes the
// current cycle's sample and saturates to the largest CW-bit value, so the
// top level can latch it directly in the closing cycle of a window.
module pwm_duty_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          pwm,
  output logic [CW-1:0] duty
);

  // One extra bit so a channel that is high for the whole period is visible
  // as 2**CW before saturation.
  logic [CW:0] cnt;
  logic [CW:0] total;

  assign total = cnt + {{CW{1'b0}}, (en & pwm)};
  assign duty  = total[CW] ? {CW{1'b1}} : total[CW-1:0];

  // Accumulate high samples; clear discards the window just finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= total;
    end
  end

endmodule

// File: rtl/pwm_color_decoder.sv
// Recovers an RGB colour from a 3-bit PWM stream and its end-of-period
// strobe. Each window runs from the cycle after one strobe up to and
// including the next strobe; a window of exactly 2**CW cycles publishes a
// new colour, anything else raises an error pulse.
module pwm_color_decoder
  import pwm_color_decoder_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        rgb_pwm_i,
  input  logic              frame_i,
  output logic [3*CW-1:0]   color_o,
  output logic              valid_o,
  output logic              error_o
);

  // len_cnt holds the number of window cycles already completed, so the
  // window is exactly one period long when a strobe arrives while it
  // reads 2**CW-1.
  localparam logic [CW:0] LEN_LAST = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0] LEN_ONE  = {{CW{1'b0}}, 1'b1};

  state_t          state;
  state_t          state_next;
  logic [CW:0]     len_cnt;
  logic [3*CW-1:0] duty_all;

  logic measuring;
  logic overrun;
  logic load_color;
  logic flag_error;
  logic clr_cnt;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a strobe opens measurement, a missing strobe drops back.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (frame_i) state_next = ST_MEASURE;
      ST_MEASURE: if (overrun) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: classify the current cycle of the window.
  always_comb begin
    measuring  = (state == ST_MEASURE);
    overrun    = measuring && !frame_i && (len_cnt == LEN_LAST);
    load_color = measuring && frame_i && (len_cnt == LEN_LAST);
    flag_error = (measuring && frame_i && (len_cnt != LEN_LAST)) || overrun;
    // Every strobe restarts the counters: in IDLE it opens a window, in
    // MEASURE it closes one and opens the next with no lost cycles.
    clr_cnt    = !measuring || frame_i || overrun;
  end

  // Window length counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_cnt <= '0;
    end else if (clr_cnt) begin
      len_cnt <= '0;
    end else begin
      len_cnt <= len_cnt + LEN_ONE;
    end
  end

  // One duty counter per channel; channel gi lands in colour slice gi, which
  // puts R (bit 2) in the top byte and B (bit 0) in the bottom byte.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pwm_duty_counter #(
        .CW (CW)
      ) u_duty (
        .clk  (clk_i),
        .rst  (rst_i),
        .clr  (clr_cnt),
        .en   (measuring),
        .pwm  (rgb_pwm_i[gi]),
        .duty (duty_all[gi*CW +: CW])
      );
    end
  endgenerate

  // Output registers: colour updates only on a well-formed period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      color_o <= '0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      if (load_color) color_o <= duty_all;
      valid_o <= load_color;
      error_o <= flag_error;
    end
  end

endmodule

// File: tb/tb_pwm_color_decoder.sv
// Randomised, self-checking bench for pwm_color_decoder. A window-level
// reference model (queue of samples per window) predicts every output each
// cycle; directed scenarios add fixed expected colours and pulse counts.
module tb_pwm_color_decoder;
  import pwm_color_decoder_pkg::*;

  localparam int CW     = 8;
  localparam int PERIOD = 1 << CW;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [2:0]     rgb_pwm_i;
  logic           frame_i;
  logic [3*CW-1:0] color_o;
  logic           valid_o;
  logic           error_o;

  pwm_color_decoder #(.CW(CW)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .rgb_pwm_i (rgb_pwm_i),
    .frame_i   (frame_i),
    .color_o   (color_o),
    .valid_o   (valid_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit           m_open;
  logic [2:0]   win_q[$];
  logic [23:0]  exp_color;
  logic         exp_valid;
  logic         exp_error;

  // Observed transactions.
  logic [23:0]  seen_q[$];
  int           n_err_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_open    = 1'b0;
    win_q.delete();
    exp_color = '0;
    exp_valid = 1'b0;
    exp_error = 1'b0;
  endtask

  // Spec-level view: collect the window's samples, judge it by its length.
  task automatic model_step(input logic [2:0] rgb, input logic frm);
    int cnt;
    exp_valid = 1'b0;
    exp_error = 1'b0;
    if (!m_open) begin
      if (frm) begin
        m_open = 1'b1;
        win_q.delete();
      end
    end else begin
      win_q.push_back(rgb);
      if (frm) begin
        if (win_q.size() == PERIOD) begin
          for (int ch = 0; ch < 3; ch++) begin
            cnt = 0;
            foreach (win_q[i]) cnt += int'(win_q[i][ch]);
            if (cnt > PERIOD - 1) cnt = PERIOD - 1;
            exp_color[ch*CW +: CW] = cnt[CW-1:0];
          end
          exp_valid = 1'b1;
        end else begin
          exp_error = 1'b1;
        end
        win_q.delete();
      end else if (win_q.size() == PERIOD) begin
        exp_error = 1'b1;
        m_open    = 1'b0;
        win_q.delete();
      end
    end
  endtask

  // One clock: drive at the falling edge, compare at the next falling edge.
  task automatic cyc(input logic [2:0] rgb, input logic frm);
    rgb_pwm_i = rgb;
    frame_i   = frm;
    @(posedge clk);
    if (rst_i) model_reset();
    else model_step(rgb, frm);
    @(negedge clk);
    chk("valid", {31'd0, valid_o}, {31'd0, exp_valid});
    chk("error", {31'd0, error_o}, {31'd0, exp_error});
    chk("color", {8'd0, color_o}, {8'd0, exp_color});
    if (valid_o) begin
      seen_q.push_back(color_o);
      $display("t=%0t valid color=%h", $time, color_o);
    end
    if (error_o) begin
      n_err_seen++;
      $display("t=%0t error color=%h", $time, color_o);
    end
  endtask

  // One PWM period of a given colour, strobe in the last cycle.
  task automatic gen_period(input logic [23:0] col);
    logic [2:0] rgb;
    for (int p = 0; p < PERIOD; p++) begin
      rgb[R_IDX] = (p < int'(col[23:16]));
      rgb[G_IDX] = (p < int'(col[15:8]));
      rgb[B_IDX] = (p < int'(col[7:0]));
      cyc(rgb, p == PERIOD - 1);
    end
  endtask

  initial begin
    int v0;
    int e0;
    int len;
    logic [2:0] rgb;

    rst_i     = 1'b1;
    rgb_pwm_i = '0;
    frame_i   = 1'b0;
    model_reset();
    #1;
    chk("rst_color", {8'd0, color_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Loopback at 7f1fff: first period only opens the window.
    v0 = seen_q.size(); e0 = n_err_seen;
    for (int k = 0; k < 4; k++) gen_period(24'h7f1fff);
    chk("loop_nvalid", seen_q.size() - v0, 3);
    chk("loop_nerr", n_err_seen - e0, 0);
    for (int i = v0; i < seen_q.size(); i++) chk("loop_color", {8'd0, seen_q[i]}, 32'h7f1fff);

    // Full-period highs: R saturates, G zero, B half.
    v0 = seen_q.size();
    for (int p = 0; p < PERIOD; p++) cyc({1'b1, 1'b0, (p < 128) ? 1'b1 : 1'b0}, p == PERIOD - 1);
    chk("sat_nvalid", seen_q.size() - v0, 1);
    chk("sat_color", {8'd0, color_o}, 32'hff0080);

    // Short period of 200 cycles: error, colour holds, next period recovers.
    e0 = n_err_seen; v0 = seen_q.size();
    for (int p = 0; p < 200; p++) cyc(3'($urandom), p == 199);
    chk("short_nerr", n_err_seen - e0, 1);
    chk("short_nvalid", seen_q.size() - v0, 0);
    chk("short_hold", {8'd0, color_o}, 32'hff0080);
    gen_period(24'h7f1fff);
    chk("short_recover", {8'd0, color_o}, 32'h7f1fff);

    // Overrun: strobe withheld for a full period, then idle, then reopen.
    e0 = n_err_seen;
    for (int p = 0; p < PERIOD; p++) cyc(3'($urandom), 1'b0);
    chk("ovr_nerr", n_err_seen - e0, 1);
    for (int p = 0; p < 5; p++) cyc(3'($urandom), 1'b0);
    chk("ovr_idle_nerr", n_err_seen - e0, 1);
    chk("ovr_hold", {8'd0, color_o}, 32'h7f1fff);
    v0 = seen_q.size();
    cyc(3'b111, 1'b1);
    gen_period(24'h123456);
    chk("ovr_nvalid", seen_q.size() - v0, 1);
    chk("ovr_color", {8'd0, color_o}, 32'h123456);

    // Asynchronous reset 100 cycles into a window.
    for (int p = 0; p < 100; p++) cyc(3'b111, 1'b0);
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_color", {8'd0, color_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    cyc(3'b111, 1'b0);
    cyc(3'b111, 1'b1);
    rst_i = 1'b0;
    v0 = seen_q.size();
    gen_period(24'habcdef);
    gen_period(24'habcdef);
    chk("mid_rst_nvalid", seen_q.size() - v0, 1);
    chk("mid_rst_color2", {8'd0, color_o}, 32'habcdef);

    // Colour change on a period boundary: no blended value in between.
    v0 = seen_q.size();
    gen_period(24'h000000);
    gen_period(24'h010203);
    chk("chg_nvalid", seen_q.size() - v0, 2);
    if (seen_q.size() - v0 == 2) begin
      chk("chg_first", {8'd0, seen_q[v0]}, 32'h000000);
      chk("chg_second", {8'd0, seen_q[v0+1]}, 32'h010203);
    end

    // Random windows: random samples, mostly correct lengths.
    for (int k = 0; k < 10; k++) begin
      len = ($urandom_range(2, 0) == 0) ? int'($urandom_range(300, 1)) : PERIOD;
      for (int p = 0; p < len; p++) begin
        rgb = 3'($urandom);
        cyc(rgb, p == len - 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
